// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for every block that owns a sprite ROM.
// Contents:
//   DEF_COLOR_W, DEF_SCREEN_W, DEF_SCREEN_H, DEF_TRANSPARENT : parameter defaults
//   blit_state_t : draw-engine state encoding (IDLE, RUN, DRAIN)
//   sprite_base() : first ROM word of a frame stored back-to-back in the ROM
package sprite_pkg;

  localparam int DEF_COLOR_W     = 3;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_TRANSPARENT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } blit_state_t;

  // Frames are packed one after another, SPR_W*SPR_H words each.
  function automatic int unsigned sprite_base(input int unsigned frame,
                                              input int unsigned spr_w,
                                              input int unsigned spr_h);
    return frame * spr_w * spr_h;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: raster-order pixel counter and ROM address generator.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   load              : clear the col/row counters (draw accepted)
//   step              : present the current pixel's address and advance
//   frame             : latched frame index (already clamped)
//   flip_x, flip_y    : latched mirror controls
//   rom_addr          : registered ROM read address
//   col, row, valid   : registered tag of the pixel whose address is on rom_addr
//   last              : counters are on the final pixel of the sprite
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int FRAMES = 24,
  localparam int FW = $clog2(FRAMES),
  localparam int AW = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          step,
  input  logic [FW-1:0] frame,
  input  logic          flip_x,
  input  logic          flip_y,
  output logic [AW-1:0] rom_addr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          valid,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(SPR_H - 1);

  logic [CW-1:0] cnt_col;
  logic [RW-1:0] cnt_row;
  logic [CW-1:0] scol;
  logic [RW-1:0] srow;
  logic [AW-1:0] addr_next;

  assign last = (cnt_col == COL_MAX) && (cnt_row == ROW_MAX);

  // Mirroring only changes which ROM word is read; the screen position
  // still follows the unmirrored col/row.
  always_comb begin
    scol      = flip_x ? (COL_MAX - cnt_col) : cnt_col;
    srow      = flip_y ? (ROW_MAX - cnt_row) : cnt_row;
    addr_next = AW'(sprite_base(32'(frame), SPR_W, SPR_H))
              + AW'(srow) * AW'(SPR_W)
              + AW'(scol);
  end

  // The counter tag is registered together with rom_addr so that downstream
  // stages see the col/row belonging to the address currently presented.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_col  <= '0;
      cnt_row  <= '0;
      rom_addr <= '0;
      col      <= '0;
      row      <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= step;
      if (load) begin
        cnt_col <= '0;
        cnt_row <= '0;
      end else if (step) begin
        if (cnt_col == COL_MAX) begin
          cnt_col <= '0;
          cnt_row <= cnt_row + 1'b1;
        end else begin
          cnt_col <= cnt_col + 1'b1;
        end
      end
      if (step) begin
        rom_addr <= addr_next;
        col      <= cnt_col;
        row      <= cnt_row;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one frame of a sprite ROM to the pixel-write port,
// one pixel per clock, with mirroring, transparency and screen clipping.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start                 : draw request, sampled only when idle
//   x_pos, y_pos          : top-left screen coordinate of the sprite
//   frame                 : frame index (out-of-range values use the last frame)
//   flip_x, flip_y        : horizontal / vertical mirror
//   rom_addr, rom_data    : synchronous sprite ROM read port (1-cycle latency)
//   x, y, color, write_en : registered pixel write
//   busy                  : draw in progress
//   done                  : one-cycle pulse after the last pixel is output
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int FRAMES      = 24,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int TRANSPARENT = DEF_TRANSPARENT,
  localparam int FW = $clog2(FRAMES),
  localparam int AW = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [9:0]         x_pos,
  input  logic [9:0]         y_pos,
  input  logic [FW-1:0]      frame,
  input  logic               flip_x,
  input  logic               flip_y,
  output logic [AW-1:0]      rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic [COLOR_W-1:0] color,
  output logic               write_en,
  output logic               busy,
  output logic               done
);

  localparam logic [COLOR_W-1:0] TRANSP_C   = COLOR_W'(TRANSPARENT);
  localparam logic [10:0]        SCREEN_W11 = 11'(SCREEN_W);
  localparam logic [10:0]        SCREEN_H11 = 11'(SCREEN_H);
  localparam logic [FW:0]        FRAMES_X   = (FW + 1)'(FRAMES);
  localparam logic [FW-1:0]      FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [1:0]         DRAIN_LAST = 2'd2;

  blit_state_t   state, next_state;
  logic          load, step, last;
  logic [1:0]    drain_cnt;

  logic [9:0]    x0, y0;
  logic [FW-1:0] frame_l, frame_clamped;
  logic          flip_x_l, flip_y_l;

  logic [CW-1:0] a_col, s1_col;
  logic [RW-1:0] a_row, s1_row;
  logic          a_valid, s1_valid;
  logic [10:0]   x11, y11;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)                   next_state = RUN;
      RUN:     if (last)                    next_state = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) next_state = IDLE;
      default:                              next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    load = (state == IDLE) && start;
    step = (state == RUN);
  end

  // DRAIN spans three cycles: two for the ROM and stage-1 registers to empty,
  // one while the final pixel sits on the output; done follows that.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : 2'd0;
      done      <= (state == DRAIN) && (drain_cnt == DRAIN_LAST);
    end
  end

  assign frame_clamped = ({1'b0, frame} >= FRAMES_X) ? FRAME_LAST : frame;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x0       <= '0;
      y0       <= '0;
      frame_l  <= '0;
      flip_x_l <= 1'b0;
      flip_y_l <= 1'b0;
    end else if (load) begin
      x0       <= x_pos;
      y0       <= y_pos;
      frame_l  <= frame_clamped;
      flip_x_l <= flip_x;
      flip_y_l <= flip_y;
    end
  end

  sprite_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .FRAMES (FRAMES)
  ) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .step     (step),
    .frame    (frame_l),
    .flip_x   (flip_x_l),
    .flip_y   (flip_y_l),
    .rom_addr (rom_addr),
    .col      (a_col),
    .row      (a_row),
    .valid    (a_valid),
    .last     (last)
  );

  // Stage 1 moves the tag in step with the ROM's own address register, so it
  // lines up with rom_data in the following cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_col   <= '0;
      s1_row   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_col   <= a_col;
      s1_row   <= a_row;
      s1_valid <= a_valid;
    end
  end

  // 11-bit sums keep the carry so a sprite hanging off the right or bottom
  // edge is clipped rather than wrapped to the left or top.
  assign x11 = {1'b0, x0} + 11'(s1_col);
  assign y11 = {1'b0, y0} + 11'(s1_row);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      color    <= '0;
      write_en <= 1'b0;
    end else begin
      write_en <= s1_valid && (rom_data != TRANSP_C)
                  && (x11 < SCREEN_W11) && (y11 < SCREEN_H11);
      if (s1_valid) begin
        x     <= x11[9:0];
        y     <= y11[9:0];
        color <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: scoreboard bench for sprite_blitter (4x4 sprites, 5 frames).
// The behavioural ROM holds (a mod 7)+1 in word a; in transparent mode every
// odd word reads 0.
module tb_sprite_blitter;

  localparam int SPR_W   = 4;
  localparam int SPR_H   = 4;
  localparam int FRAMES  = 5;
  localparam int COLOR_W = 3;
  localparam int FW      = $clog2(FRAMES);
  localparam int AW      = $clog2(FRAMES * SPR_W * SPR_H);

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [9:0]         x_pos, y_pos;
  logic [FW-1:0]      frame;
  logic               flip_x, flip_y;
  logic [AW-1:0]      rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [9:0]         x, y;
  logic [COLOR_W-1:0] color;
  logic               write_en, busy, done;

  typedef struct packed {
    logic [9:0]         x;
    logic [9:0]         y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  pix_t exp_q[$];

  bit   rom_mode;
  int   checks;
  int   errors;
  int   cyc;
  int   wr_count, first_wr_cyc, last_wr_cyc, busy_count, done_count, done_cyc;
  logic [COLOR_W-1:0] first_color, last_color;

  sprite_blitter #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .FRAMES (FRAMES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .frame    (frame),
    .flip_x   (flip_x),
    .flip_y   (flip_y),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .color    (color),
    .write_en (write_en),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [COLOR_W-1:0] rom_word(input int a, input bit mode);
    if (mode && (a % 2 == 1)) return '0;
    return COLOR_W'((a % 7) + 1);
  endfunction

  always @(posedge clk) rom_data <= rom_word(int'(rom_addr), rom_mode);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    wr_count     = 0;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    busy_count   = 0;
    done_count   = 0;
    done_cyc     = -1;
    first_color  = '0;
    last_color   = '0;
  endtask

  // Expected write list for one draw; only the first 'limit' pixels are queued.
  function automatic void pushDraw(input int x0, input int y0, input int fr,
                                   input bit fx, input bit fy, input int limit);
    int col, row, sc, sr, a, xx, yy;
    logic [COLOR_W-1:0] c;
    pix_t p;
    if (fr >= FRAMES) fr = FRAMES - 1;
    for (int i = 0; i < limit; i++) begin
      col = i % SPR_W;
      row = i / SPR_W;
      sc  = fx ? SPR_W - 1 - col : col;
      sr  = fy ? SPR_H - 1 - row : row;
      a   = fr * SPR_W * SPR_H + sr * SPR_W + sc;
      c   = rom_word(a, rom_mode);
      xx  = x0 + col;
      yy  = y0 + row;
      if (c != 0 && xx < 640 && yy < 480) begin
        p.x = 10'(xx);
        p.y = 10'(yy);
        p.c = c;
        exp_q.push_back(p);
      end
    end
  endfunction

  // Issues a one-cycle start and scrambles the inputs afterwards; k is the
  // index of the accepting edge.
  task automatic applyStimulus(input int x0, input int y0, input int fr,
                               input bit fx, input bit fy, output int k);
    @(negedge clk);
    clearStats();
    x_pos  = 10'(x0);
    y_pos  = 10'(y0);
    frame  = FW'(fr);
    flip_x = fx;
    flip_y = fy;
    start  = 1'b1;
    @(posedge clk);
    #1;
    k      = cyc;
    start  = 1'b0;
    x_pos  = ~x_pos;
    y_pos  = ~y_pos;
    frame  = '0;
    flip_x = ~fx;
    flip_y = ~fy;
  endtask

  task automatic waitDone(output int dc);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    dc = cyc;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within 200 cycles, expected a done pulse");
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a pixel.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_count++;
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    if (write_en === 1'b1) begin
      if (wr_count == 0) begin
        first_wr_cyc = cyc;
        first_color  = color;
      end
      last_wr_cyc = cyc;
      last_color  = color;
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got write at x=%0d y=%0d color=%0d, expected none",
                 x, y, color);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        checkOutput("pixel", 32'({x, y, color}), 32'(e));
      end
    end
  end

  initial begin
    int k, d, d1, d2;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rom_mode = 1'b0;
    reset_n  = 1'b0;
    start    = 1'b0;
    x_pos    = '0;
    y_pos    = '0;
    frame    = '0;
    flip_x   = 1'b0;
    flip_y   = 1'b0;
    clearStats();

    repeat (3) @(negedge clk);
    checkOutput("reset_state", 32'({x, y, color, write_en, busy, done, rom_addr}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic draw, frame 2 -> words 32..47
    pushDraw(10, 20, 2, 1'b0, 1'b0, 16);
    applyStimulus(10, 20, 2, 1'b0, 1'b0, k);
    waitDone(d);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("done_latency", 32'(d - k), 32'd19);
    checkOutput("first_wr_latency", 32'(first_wr_cyc - k), 32'd3);
    checkOutput("last_wr_latency", 32'(last_wr_cyc - k), 32'd18);
    checkOutput("basic_wr_count", 32'(wr_count), 32'd16);
    checkOutput("busy_cycles", 32'(busy_count), 32'd19);
    checkOutput("basic_first_color", 32'(first_color), 32'd5);
    checkOutput("basic_last_color", 32'(last_color), 32'd6);
    repeat (3) @(negedge clk);
    checkOutput("done_width", 32'(done_count), 32'd1);
    checkOutput("basic_queue", 32'(exp_q.size()), 32'd0);

    // Both mirrors, frame 0: first pixel from word 15, last from word 0
    pushDraw(200, 300, 0, 1'b1, 1'b1, 16);
    applyStimulus(200, 300, 0, 1'b1, 1'b1, k);
    waitDone(d);
    checkOutput("flip_first_color", 32'(first_color), 32'd2);
    checkOutput("flip_last_color", 32'(last_color), 32'd1);
    checkOutput("flip_wr_count", 32'(wr_count), 32'd16);
    checkOutput("flip_queue", 32'(exp_q.size()), 32'd0);

    // Odd words transparent
    repeat (2) @(negedge clk);
    rom_mode = 1'b1;
    pushDraw(0, 0, 1, 1'b0, 1'b0, 16);
    applyStimulus(0, 0, 1, 1'b0, 1'b0, k);
    waitDone(d);
    checkOutput("transp_wr_count", 32'(wr_count), 32'd8);
    checkOutput("transp_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rom_mode = 1'b0;

    // Right-edge clip: only columns 638, 639
    pushDraw(638, 100, 1, 1'b0, 1'b0, 16);
    applyStimulus(638, 100, 1, 1'b0, 1'b0, k);
    waitDone(d);
    checkOutput("clipx_wr_count", 32'(wr_count), 32'd8);
    checkOutput("clipx_queue", 32'(exp_q.size()), 32'd0);

    // Fully below the screen: nothing written, done still pulses
    pushDraw(50, 1023, 3, 1'b0, 1'b0, 16);
    applyStimulus(50, 1023, 3, 1'b0, 1'b0, k);
    waitDone(d);
    checkOutput("clipy_wr_count", 32'(wr_count), 32'd0);
    checkOutput("clipy_done_latency", 32'(d - k), 32'd19);

    // Out-of-range frame 5 -> last frame 4, words 64..79
    pushDraw(30, 40, 5, 1'b0, 1'b0, 16);
    applyStimulus(30, 40, 5, 1'b0, 1'b0, k);
    waitDone(d);
    checkOutput("clamp_first_color", 32'(first_color), 32'd2);
    checkOutput("clamp_last_color", 32'(last_color), 32'd3);
    checkOutput("clamp_queue", 32'(exp_q.size()), 32'd0);

    // start held high: back-to-back draws every 20 cycles
    pushDraw(100, 50, 1, 1'b0, 1'b0, 16);
    pushDraw(100, 50, 1, 1'b0, 1'b0, 16);
    @(negedge clk);
    clearStats();
    x_pos  = 10'd100;
    y_pos  = 10'd50;
    frame  = FW'(1);
    flip_x = 1'b0;
    flip_y = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    waitDone(d1);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(d2);
    checkOutput("hold_first_done", 32'(d1 - k), 32'd19);
    checkOutput("hold_period", 32'(d2 - d1), 32'd20);
    checkOutput("hold_wr_count", 32'(wr_count), 32'd32);
    checkOutput("hold_busy_cycles", 32'(busy_count), 32'd38);
    checkOutput("hold_queue", 32'(exp_q.size()), 32'd0);

    // start pulse during a draw is ignored
    repeat (2) @(negedge clk);
    pushDraw(300, 200, 2, 1'b0, 1'b1, 16);
    applyStimulus(300, 200, 2, 1'b0, 1'b1, k);
    repeat (5) @(negedge clk);
    x_pos = 10'd0;
    y_pos = 10'd0;
    frame = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(d);
    repeat (30) @(negedge clk);
    checkOutput("mid_start_done_count", 32'(done_count), 32'd1);
    checkOutput("mid_start_wr_count", 32'(wr_count), 32'd16);
    checkOutput("mid_start_queue", 32'(exp_q.size()), 32'd0);

    // Reset at pixel 7: pixels 0..6 already out, then everything clears
    pushDraw(400, 10, 3, 1'b0, 1'b0, 7);
    applyStimulus(400, 10, 3, 1'b0, 1'b0, k);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mid_outputs", 32'({x, y, color, write_en, busy, done, rom_addr}), 32'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("reset_no_done", 32'(done_count), 32'd0);
    checkOutput("reset_wr_count", 32'(wr_count), 32'd7);
    checkOutput("reset_queue", 32'(exp_q.size()), 32'd0);

    pushDraw(400, 10, 3, 1'b0, 1'b0, 16);
    applyStimulus(400, 10, 3, 1'b0, 1'b0, k);
    waitDone(d);
    checkOutput("post_reset_latency", 32'(d - k), 32'd19);
    checkOutput("post_reset_wr_count", 32'(wr_count), 32'd16);
    checkOutput("post_reset_queue", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
